// File: rtl/div_pkg.sv
// div_pkg: shared defaults and slot record for the divider feeder
package div_pkg;
  localparam int WN_DEF     = 8;
  localparam int WD_DEF     = 6;
  localparam int DEPTH_DEF  = 4;
  localparam int PERIOD_DEF = 18;
  typedef struct packed {
    logic v;
    logic dz;
  } slot_t;
endpackage

// File: rtl/div_fifo.sv
// div_fifo: registered operand FIFO with wrap-bit pointers
module div_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wp, rp;
  logic [W-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/div_feed.sv
// div_feed: feeds queued operands to a fixed-period divider and collects results in order
module div_feed
  import div_pkg::*;
#(
  parameter int WN     = WN_DEF,
  parameter int WD     = WD_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic [WN-1:0] n_div,
  output logic [WD-1:0] d_div,
  input  logic [WN-1:0] q_div,
  input  logic [WD-1:0] r_div,
  output logic          res_valid,
  output logic [WN-1:0] res_q,
  output logic [WD-1:0] res_r,
  output logic          res_dz
);
  localparam int PW = $clog2(PERIOD);
  logic [PW-1:0]  ph;
  logic [WN+WD:0] head;
  logic           full, empty, push, pop, last, issue, issue_dz;
  slot_t          slot0, slot1;
  assign last     = ph == PW'(PERIOD - 1);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = last && !empty;
  div_fifo #(.W(WN + WD + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({n_in, d_in, d_in == '0}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // issue/issue_dz describe the division just loaded; the tracker ages it one period per stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      ph        <= '0;
      issue     <= 1'b0;
      issue_dz  <= 1'b0;
      slot0     <= '0;
      slot1     <= '0;
      n_div     <= '0;
      d_div     <= '0;
      res_q     <= '0;
      res_r     <= '0;
      res_valid <= 1'b0;
      res_dz    <= 1'b0;
    end else begin
      ph        <= last ? '0 : ph + PW'(1);
      res_valid <= ph == '0 && slot1.v;
      if (last) begin
        issue    <= !empty;
        issue_dz <= !empty && head[0];
        slot0    <= '{v: issue, dz: issue_dz};
        slot1    <= slot0;
      end
      if (pop) begin
        n_div <= head[WN+WD:WD+1];
        d_div <= head[WD:1];
      end
      if (ph == '0 && slot1.v) begin
        res_q  <= slot1.dz ? '1 : q_div;
        res_r  <= slot1.dz ? '0 : r_div;
        res_dz <= slot1.dz;
      end
    end
  end
endmodule

// File: tb/tb_div_feed.sv
// tb_div_feed: randomized and directed checks of div_feed against a queue-based reference
module tb_div_feed;
  localparam int WN = 8, WD = 6, DEPTH = 4, P = 18;
  logic          clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_ready;
  logic [WN-1:0] n_in = '0, n_div, q_div = '0, res_q;
  logic [WD-1:0] d_in = '0, d_div, r_div = '0, res_r;
  logic          res_valid, res_dz;
  int            n_cmp = 0, n_bad = 0, cyc = 0, mph = 0;
  typedef struct {logic [WN-1:0] n; logic [WD-1:0] d;} op_t;
  typedef struct {int due; logic [WN-1:0] q; logic [WD-1:0] r; logic dz;} res_t;
  op_t           fq[$];
  res_t          pq[$];
  logic [WN-1:0] m_ndiv = '0, m_rq = '0, dv_qm = '0, dv_qo = '0, ns;
  logic [WD-1:0] m_ddiv = '0, m_rr = '0, dv_rm = '0, dv_ro = '0, ds;
  logic          m_rv = 1'b0, m_dz = 1'b0, a;

  always #5 clk = ~clk;

  div_feed #(.WN(WN), .WD(WD), .DEPTH(DEPTH), .PERIOD(P)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .d_in(d_in), .n_div(n_div), .d_div(d_div),
    .q_div(q_div), .r_div(r_div), .res_valid(res_valid),
    .res_q(res_q), .res_r(res_r), .res_dz(res_dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // one clock: drive at negedge, advance the reference at posedge, compare at next negedge
  task automatic step(input logic v, input logic [WN-1:0] n, input logic [WD-1:0] d,
                      input logic rn, output logic acc);
    logic pop_m;
    res_t r;
    op_t  o;
    in_valid = v; n_in = n; d_in = d; reset = rn;
    check("in_ready", 32'(in_ready), 32'(fq.size() < DEPTH));
    acc = rn && v && fq.size() < DEPTH;
    ns = n_div; ds = d_div;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      fq.delete(); pq.delete();
      mph = 0; m_ndiv = '0; m_ddiv = '0; m_rq = '0; m_rr = '0; m_rv = 0; m_dz = 0;
      dv_qm = '0; dv_rm = '0; dv_qo = '0; dv_ro = '0;
    end else begin
      pop_m = mph == P - 1 && fq.size() > 0;
      if (mph == 0) begin
        dv_qo = dv_qm; dv_ro = dv_rm;
        dv_qm = ds == 0 ? WN'(8'hA5) : ns / WN'(ds);
        dv_rm = ds == 0 ? WD'(6'h2A) : WD'(ns % WN'(ds));
      end
      m_rv = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        r = pq.pop_front();
        m_rv = 1'b1; m_rq = r.q; m_rr = r.r; m_dz = r.dz;
      end
      if (pop_m) begin
        o = fq.pop_front();
        m_ndiv = o.n; m_ddiv = o.d;
        r.due = cyc + 2 * P + 1;
        r.dz  = o.d == 0;
        r.q   = r.dz ? '1 : o.n / WN'(o.d);
        r.r   = r.dz ? '0 : WD'(o.n % WN'(o.d));
        pq.push_back(r);
      end
      if (acc) begin
        o.n = n; o.d = d;
        fq.push_back(o);
      end
      mph = mph == P - 1 ? 0 : mph + 1;
    end
    @(negedge clk);
    q_div = dv_qo; r_div = dv_ro;
    check("res_valid", 32'(res_valid), 32'(m_rv));
    check("n_div", 32'(n_div), 32'(m_ndiv));
    check("d_div", 32'(d_div), 32'(m_ddiv));
    check("res_q", 32'(res_q), 32'(m_rq));
    check("res_r", 32'(res_r), 32'(m_rr));
    if (m_rv) check("res_dz", 32'(res_dz), 32'(m_dz));
  endtask

  task automatic idle(input int k);
    logic x;
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b1, x);
  endtask

  task automatic send(input logic [WN-1:0] n, input logic [WD-1:0] d);
    logic x = 1'b0;
    for (int i = 0; i < 4 * P && !x; i++) step(1'b1, n, d, 1'b1, x);
    check("send_accepted", 32'(x), 32'd1);
  endtask

  task automatic align();
    logic x;
    for (int i = 0; i < P && mph != 0; i++) step(1'b0, '0, '0, 1'b1, x);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    step(1'b0, '0, '0, 1'b0, a);
    idle(3);
    send(8'd100, 6'd7);
    idle(3 * P + 5);
    send(8'd255, 6'd1);
    send(8'd0, 6'd5);
    idle(4 * P);
    send(8'd37, 6'd0);
    idle(3 * P + 5);
    align();
    for (int i = 0; i < 6; i++) send(WN'(20 + 13 * i), WD'(i + 2));
    idle(8 * P);
    align();
    for (int i = 0; i < 4; i++) send(WN'(200 - 9 * i), WD'(3 + i));
    idle(2 * P - 4);
    step(1'b0, '0, '0, 1'b0, a);
    send(8'd9, 6'd3);
    idle(3 * P + 5);
    for (int i = 0; i < 300; i++) begin
      ns = WN'($urandom);
      ds = ($urandom_range(7) == 0) ? '0 : WD'($urandom);
      step(1'($urandom), ns, ds, 1'b1, a);
    end
    idle(8 * P);
    check("drained", 32'(fq.size() + pq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
